// File: rtl/lcd_draw_scheduler.sv
// lcd_draw_scheduler
// Shares the single parallel-LCD draw engine between the sprite clients
// (dino, cactus, score, banner) and a full-screen clear. Requests are
// latched into a pending set. A pending clear always wins. Sprite clients
// are granted round-robin. Each grant gives one start pulse to the engine,
// waits for its completion (or a watchdog abort), and then returns a
// one-cycle done pulse to the winning client.
//
// Ports:
//   clk          system clock, all logic on posedge
//   rst          asynchronous active-low reset
//   req          per-client draw request (bit0 dino, bit1 cactus, bit2 score, bit3 banner)
//   clear_req    full-screen clear request, highest priority
//   eng_done     one-cycle completion pulse from the draw engine
//   eng_start    one-cycle start pulse to the draw engine
//   eng_sel      id of the client being served (N_REQ means clear)
//   done         one-cycle completion pulse to the served sprite client
//   clear_done   one-cycle completion pulse for the clear
//   pending      latched requests, {clear, req}
//   busy         high whenever a transaction is in progress
//   timeout_err  sticky flag, set when the watchdog aborts a transfer

module lcd_draw_scheduler #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1024,
    parameter int SEL_W   = $clog2(N_REQ + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             clear_req,
    input  logic             eng_done,
    output logic             eng_start,
    output logic [SEL_W-1:0] eng_sel,
    output logic [N_REQ-1:0] done,
    output logic             clear_done,
    output logic [N_REQ:0]   pending,
    output logic             busy,
    output logic             timeout_err
);

    localparam int               TMR_W    = $clog2(TIMEOUT + 1);
    localparam logic [SEL_W-1:0] CLEAR_ID = SEL_W'(N_REQ);
    localparam logic [SEL_W-1:0] LAST_ID  = SEL_W'(N_REQ - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK
    } state_t;

    state_t             state;
    logic [SEL_W-1:0]   rr;
    logic [TMR_W-1:0]   timer;
    logic               win_valid;
    logic [SEL_W-1:0]   win_sel;
    logic [2*N_REQ-1:0] rot;
    logic [N_REQ:0]     set_mask;
    logic [N_REQ:0]     clr_mask;
    int                 idx;

    // Pick the next client to serve from the pending set. A pending clear
    // wins outright. Otherwise the sprite bits are rotated so that bit 0 of
    // the rotated vector is the client at the round-robin pointer. The loop
    // runs from the far end down, so the last write is the first set bit at
    // or after the pointer.
    always_comb begin
        win_valid = 1'b0;
        win_sel   = '0;
        idx       = 0;
        rot       = {pending[N_REQ-1:0], pending[N_REQ-1:0]} >> rr;
        if (pending[N_REQ]) begin
            win_valid = 1'b1;
            win_sel   = CLEAR_ID;
        end else begin
            for (int k = N_REQ - 1; k >= 0; k--) begin
                if (rot[k]) begin
                    win_valid = 1'b1;
                    idx       = int'(rr) + k;
                    if (idx >= N_REQ) begin
                        idx = idx - N_REQ;
                    end
                    win_sel = SEL_W'(idx);
                end
            end
        end
    end

    // New requests are ORed in on every edge. The served bit is dropped
    // only while in ACK. Set is applied after clear, so a request that
    // arrives on the ACK edge itself is kept for a later grant.
    assign set_mask = {clear_req, req};
    assign clr_mask = (state == ACK) ? ((N_REQ + 1)'(1) << eng_sel) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | set_mask;
        end
    end

    // Main sequencer with registered Moore outputs. IDLE latches the winner
    // into eng_sel. ISSUE is the single start-pulse cycle. WAIT counts
    // engine cycles. The watchdog fires after TIMEOUT cycles in WAIT, so a
    // hung engine cannot block the other clients. ACK is the one cycle in
    // which the client sees its done pulse. The round-robin pointer moves
    // only after a sprite grant, never after a clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            rr          <= '0;
            timer       <= '0;
            eng_start   <= 1'b0;
            eng_sel     <= '0;
            done        <= '0;
            clear_done  <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            eng_start  <= 1'b0;
            done       <= '0;
            clear_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        eng_sel   <= win_sel;
                        eng_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (eng_done || (timer == TMR_LAST)) begin
                        if (!eng_done) begin
                            timeout_err <= 1'b1;
                        end
                        if (eng_sel == CLEAR_ID) begin
                            clear_done <= 1'b1;
                        end else begin
                            done <= N_REQ'(1) << eng_sel;
                        end
                        state <= ACK;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ACK: begin
                    if (eng_sel != CLEAR_ID) begin
                        rr <= (eng_sel == LAST_ID) ? '0 : eng_sel + 1'b1;
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
